mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the word-address width of the data RAM (byte address bits [ADDR_W+1:2]).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 1, access request from the pipeline MEM stage.
REQ-005 SHALL have port wr, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have ports w, h, b, input, 1 each, access size word/halfword/byte.
REQ-007 SHALL have port z, input, 1, load extension: 1 = zero-extend, 0 = sign-extend.
REQ-008 SHALL have ports addr and wdata, input, 32 each: the byte address and the store data (sub-word data in the low bits).
REQ-009 SHALL have port rdata, output, 32, the aligned and extended load result.
REQ-010 SHALL have port stall, output, 1, which holds the pipeline.
REQ-011 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port addr_err, output, 1, an alignment/size error flag that is valid while done=1.
REQ-013 SHALL have ports ram_ena, ram_wena, output, 1 each, the RAM enable and write enable.
REQ-014 SHALL have port ram_addr, output, ADDR_W, the RAM word address.
REQ-015 SHALL have port ram_wdata, output, 32, the full-word write data.
REQ-016 SHALL have port ram_rdata, input, 32, the RAM read data, valid one cycle after a read-enable cycle.

Function
REQ-017 SHALL implement the states IDLE, RD, CAP, WR and DONE.
REQ-018 SHALL accept a request only when req=1 in IDLE, registering wr, w, h, b, z, addr and wdata at that edge; req in any other state is ignored.
REQ-019 SHALL flag an error when the size flags are not exactly one-hot, when w=1 and addr[1:0]!=0, or when h=1 and addr[0]=1.
REQ-020 SHALL, on an error, go IDLE->DONE with no RAM access, assert addr_err=1 and set rdata=0.
REQ-021 SHALL run loads as IDLE->RD->CAP->DONE->IDLE:
  - RD drives ram_ena=1 and ram_wena=0;
  - CAP registers the extracted value into rdata.
REQ-022 SHALL run word stores as IDLE->WR->DONE->IDLE; WR drives ram_ena=1, ram_wena=1 and ram_wdata=wdata.
REQ-023 SHALL run byte/half stores as read-modify-write IDLE->RD->CAP->WR->DONE->IDLE:
  - CAP merges the new lane into the registered read word;
  - all other bytes are preserved.
REQ-024 SHALL use little-endian lanes:
  - byte k occupies bits [8k+7:8k], k=addr[1:0];
  - the halfword is at [15:0] if addr[1]=0 and at [31:16] otherwise.
REQ-025 SHALL extend byte and half loads to 32 bits per z; word loads pass through unchanged.
REQ-026 SHALL drive ram_addr=addr[ADDR_W+1:2] from the registered address in every non-IDLE state.
REQ-027 SHALL hold ram_ena=0 in IDLE, CAP and DONE.
REQ-028 SHALL assert stall combinationally when (state==IDLE and req=1), or in RD, CAP or WR; stall=0 in DONE.
REQ-029 SHALL assert done for exactly the one DONE cycle; rdata holds its value until the next load completes.
REQ-030 SHALL have these cycle latencies from the accept edge to done=1:
  - load: 3;
  - word store: 2;
  - sub-word store: 4;
  - error: 1.
REQ-031 SHALL accept a req present in the first IDLE cycle after DONE; back-to-back requests therefore lose no cycles beyond DONE.

Reset
REQ-032 SHALL, while rst_n=0, force state=IDLE, rdata=0, done=0, addr_err=0, ram_ena=0, ram_wena=0, ram_addr=0 and ram_wdata=0; stall then follows only req.
REQ-033 SHALL abandon any in-flight access on reset, with no RAM write occurring after rst_n falls.

Verification
REQ-034 SHALL pass this byte load: RAM word 0 = 0x80FF7F01; lb (b=1, z=0) at addr 0x3 -> done at accept+3, rdata=0xFFFFFF80; with z=1 -> rdata=0x00000080.
REQ-035 SHALL pass this halfword store: RAM word 1 = 0x11223344; sh (h=1, wr=1) at addr 0x6 with wdata=0x0000BEEF -> one read then one write; RAM word 1 becomes 0xBEEF3344; done at accept+4.
REQ-036 SHALL pass this error case: lw at addr 0x2 -> done and addr_err=1 at accept+1, ram_ena never high, rdata=0.
REQ-037 SHALL pass this back-to-back case: sw to 0x8 with 0xDEADBEEF, then req held high for lw at 0x8 -> the second access starts in the IDLE cycle after DONE and returns rdata=0xDEADBEEF.
REQ-038 SHALL pass this reset-mid-access case: rst_n pulled low in the RMW state CAP -> immediate IDLE and all outputs zero; the RAM word is unchanged and no done pulse occurs.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the pipeline MEM stage: aligned word/half/byte
// loads and stores against a synchronous-read RAM, with read-modify-write for sub-word stores.
module mem_access_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic              w,
  input  logic              h,
  input  logic              b,
  input  logic              z,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              addr_err,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } state_t;

  state_t state, state_nx;

  logic              op_wr, op_w, op_h, op_z, op_err;
  logic [ADDR_W+1:0] op_addr;
  logic [31:0]       wbuf;
  logic              req_err;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  // Byte-address bits above the RAM's reach play no part in the access.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    req_err = 1'b1;
    case ({w, h, b})
      3'b100:  req_err = (addr[1:0] != 2'b00);
      3'b010:  req_err = addr[0];
      3'b001:  req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
  end

  // Lane extraction and merge both work on the word the RAM presents during CAP.
  always_comb begin
    lane_b = ram_rdata[7:0];
    case (op_addr[1:0])
      2'd0:    lane_b = ram_rdata[7:0];
      2'd1:    lane_b = ram_rdata[15:8];
      2'd2:    lane_b = ram_rdata[23:16];
      default: lane_b = ram_rdata[31:24];
    endcase
    lane_h = op_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    if (op_w)
      load_val = ram_rdata;
    else if (op_h)
      load_val = op_z ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
    else
      load_val = op_z ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};

    merged = ram_rdata;
    if (op_h) begin
      if (op_addr[1])
        merged[31:16] = wbuf[15:0];
      else
        merged[15:0] = wbuf[15:0];
    end else begin
      case (op_addr[1:0])
        2'd0:    merged[7:0]   = wbuf[7:0];
        2'd1:    merged[15:8]  = wbuf[7:0];
        2'd2:    merged[23:16] = wbuf[7:0];
        default: merged[31:24] = wbuf[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    done      = 1'b0;
    addr_err  = 1'b0;
    ram_ena   = 1'b0;
    ram_wena  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state)
      IDLE: begin
        stall = req;
        if (req) begin
          if (req_err)
            state_nx = DONE;
          else if (wr && w)
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD: begin
        stall    = 1'b1;
        ram_ena  = 1'b1;
        ram_addr = op_addr[ADDR_W+1:2];
        state_nx = CAP;
      end
      CAP: begin
        stall    = 1'b1;
        ram_addr = op_addr[ADDR_W+1:2];
        state_nx = op_wr ? WR : DONE;
      end
      WR: begin
        stall     = 1'b1;
        ram_ena   = 1'b1;
        ram_wena  = 1'b1;
        ram_addr  = op_addr[ADDR_W+1:2];
        ram_wdata = wbuf;
        state_nx  = DONE;
      end
      DONE: begin
        done     = 1'b1;
        addr_err = op_err;
        ram_addr = op_addr[ADDR_W+1:2];
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // wbuf carries the store data until CAP, then the merged word for sub-word stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr   <= 1'b0;
      op_w    <= 1'b0;
      op_h    <= 1'b0;
      op_z    <= 1'b0;
      op_err  <= 1'b0;
      op_addr <= '0;
      wbuf    <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= wr;
            op_w    <= w;
            op_h    <= h;
            op_z    <= z;
            op_err  <= req_err;
            op_addr <= addr[ADDR_W+1:0];
            wbuf    <= wdata;
            if (req_err)
              rdata <= '0;
          end
        end
        CAP: begin
          if (op_wr)
            wbuf <= merged;
          else
            rdata <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a behavioural RAM image and load/store rules
// predict latency, RAM traffic, error flag, load result and final memory contents.
module tb_mem_access_ctrl;

  localparam int AW = 4;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          wr = 1'b0, w = 1'b0, h = 1'b0, b = 1'b0, z = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic [31:0]   rdata;
  logic          stall, done, addr_err, ram_ena, ram_wena;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;

  bit   [31:0]   mem [NW];
  bit   [31:0]   ref_mem [NW];
  logic [31:0]   exp_rdata = '0;
  int            errors = 0;
  int            checks = 0;

  mem_access_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .w(w), .h(h), .b(b), .z(z),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
    .addr_err(addr_err), .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wena) mem[ram_addr] <= ram_wdata;
      else          ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr_i, w_i, h_i, b_i, z_i, input logic [31:0] a, d);
    req = 1'b1; wr = wr_i; w = w_i; h = h_i; b = b_i; z = z_i; addr = a; wdata = d;
  endtask

  task automatic run_op(input logic wr_i, w_i, h_i, b_i, z_i, input logic [31:0] a, d,
                        input bit pre, input bit keep);
    int idx, lat, nrd, nwr, exp_lat, exp_rd, exp_wr, sh;
    logic err;
    logic [31:0] word, mask, v;
    idx = int'(a[AW+1:2]);
    err = ((int'(w_i) + int'(h_i) + int'(b_i)) != 1) || (w_i && a[1:0] != 2'b00) || (h_i && a[0]);
    exp_lat = err ? 1 : (!wr_i ? 3 : (w_i ? 2 : 4));
    exp_rd  = (err || (wr_i && w_i)) ? 0 : 1;
    exp_wr  = (!err && wr_i) ? 1 : 0;

    if (!pre) begin
      @(negedge clk);
      drive(wr_i, w_i, h_i, b_i, z_i, a, d);
      #1 check("idle_req_stall", 32'(stall), 32'd1);
    end else begin
      @(posedge clk); #1;
      check("b2b_idle_stall", 32'(stall), 32'd1);
      check("b2b_idle_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    req = 1'b0;
    nrd = 0; nwr = 0; lat = 1;
    while (1) begin
      if (ram_ena) begin
        if (ram_wena) nwr++; else nrd++;
        check("ram_addr", 32'(ram_addr), 32'(idx));
      end
      if (done || lat >= 8) break;
      check("stall_busy", 32'(stall), 32'd1);
      @(posedge clk); #1;
      lat++;
    end

    if (err) exp_rdata = '0;
    else if (!wr_i) begin
      word = ref_mem[idx];
      if (w_i) v = word;
      else if (h_i) begin
        v = (word >> (16 * int'(a[1]))) & 32'h0000FFFF;
        if (!z_i && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = (word >> (8 * int'(a[1:0]))) & 32'h000000FF;
        if (!z_i && v[7]) v = v | 32'hFFFFFF00;
      end
      exp_rdata = v;
    end else begin
      if (w_i) ref_mem[idx] = d;
      else begin
        sh   = h_i ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
        mask = (h_i ? 32'h0000FFFF : 32'h000000FF) << sh;
        ref_mem[idx] = (ref_mem[idx] & ~mask) | ((d << sh) & mask);
      end
    end

    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("stall_done", 32'(stall), 32'd0);
    check("addr_err", 32'(addr_err), 32'(err));
    check("ram_reads", 32'(nrd), 32'(exp_rd));
    check("ram_writes", 32'(nwr), 32'(exp_wr));
    check("rdata", rdata, exp_rdata);
    if (wr_i && !err) check("ram_word", mem[idx], ref_mem[idx]);
    if (!keep) begin
      @(posedge clk); #1;
      check("done_pulse", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int r;
    logic [2:0] sz;
    logic [31:0] a;

    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_ram_ena", 32'(ram_ena), 32'd0);
    check("rst_ram_wena", 32'(ram_wena), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_stall_lo", 32'(stall), 32'd0);
    req = 1'b1;
    #1 check("rst_stall_hi", 32'(stall), 32'd1);
    req = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    run_op(1, 1, 0, 0, 0, 32'h0, 32'h80FF7F01, 0, 0);
    run_op(0, 0, 0, 1, 0, 32'h3, 32'h0, 0, 0);
    check("lb_sext", rdata, 32'hFFFFFF80);
    run_op(0, 0, 0, 1, 1, 32'h3, 32'h0, 0, 0);
    check("lbu_zext", rdata, 32'h00000080);

    run_op(1, 1, 0, 0, 0, 32'h4, 32'h11223344, 0, 0);
    run_op(1, 0, 1, 0, 0, 32'h6, 32'h0000BEEF, 0, 0);
    check("sh_rmw_word", mem[1], 32'hBEEF3344);

    run_op(0, 1, 0, 0, 0, 32'h2, 32'h0, 0, 0);
    check("err_rdata", rdata, 32'h0);

    run_op(1, 1, 0, 0, 0, 32'h8, 32'hDEADBEEF, 0, 1);
    drive(0, 1, 0, 0, 0, 32'h8, 32'h0);
    run_op(0, 1, 0, 0, 0, 32'h8, 32'h0, 1, 0);
    check("b2b_rdata", rdata, 32'hDEADBEEF);

    @(negedge clk);
    drive(1, 0, 1, 0, 0, 32'h4, 32'h00001234);
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_ram_ena", 32'(ram_ena), 32'd0);
    check("mid_rst_ram_wena", 32'(ram_wena), 32'd0);
    check("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_ram_wdata", ram_wdata, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", 32'(done), 32'd0);
      check("mid_rst_no_ram", 32'(ram_ena), 32'd0);
    end
    check("mid_rst_word", mem[1], ref_mem[1]);
    exp_rdata = '0;
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2: sz = 3'b100;
        3, 4, 5: sz = 3'b010;
        6, 7, 8: sz = 3'b001;
        default: sz = 3'($urandom);
      endcase
      a = ($urandom & 32'hFFFFFFC0) | 32'($urandom_range(0, 63));
      if (sz == 3'b100 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (sz == 3'b010 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      run_op(1'($urandom), sz[2], sz[1], sz[0], 1'($urandom), a, $urandom, 0, 0);
    end

    for (int k = 0; k < NW; k++) check("final_mem", mem[k], ref_mem[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
